// File: rtl/ram_bist.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bist
//  Description : March-test BIST sequencer for a 2**AW x DW synchronous RAM.
//                Runs four elements: write background (asc), read/invert
//                (asc), read/invert (desc), read (desc); reports pass/fail,
//                first failing address and the data read there.
//                Optional macro BIST_ERRCNT_EN: adds a saturating 8-bit
//                mismatch counter and runs to completion instead of aborting.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_bist #(
    parameter int              DW  = 8,
    parameter int              AW  = 4,
    parameter logic [DW-1:0]   PAT = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [DW-1:0] ram_d,
    output logic [AW-1:0] ram_addr,
    output logic          ram_cs,
    output logic          ram_rw,
`ifdef BIST_ERRCNT_EN
    output logic [7:0]    err_cnt,
`endif
    input  logic [DW-1:0] ram_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_M0_WR = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [AW-1:0] A_FIRST = {AW{1'b0}};
    localparam logic [AW-1:0] A_LAST  = {AW{1'b1}};

    logic [2:0]    state_q,     state_d;
    logic [1:0]    e_q,         e_d;
    logic [AW-1:0] a_q,         a_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          pass_q,      pass_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic [DW-1:0] ram_d_q,     ram_d_d;
    logic [AW-1:0] ram_addr_q,  ram_addr_d;
    logic          ram_cs_q,    ram_cs_d;
    logic          ram_rw_q,    ram_rw_d;
`ifdef BIST_ERRCNT_EN
    logic [7:0]    err_cnt_q,   err_cnt_d;
`endif

    logic [DW-1:0] exp_data;
    logic          mismatch;

    // Element 2 expects the inverted background; elements 1 and 3 expect PAT.
    always_comb begin
        exp_data = (e_q == 2'd2) ? ~PAT : PAT;
        mismatch = (ram_o != exp_data);
    end

    // March sequencing: next state, address/element counters and status.
    always_comb begin
        state_d     = state_q;
        e_d         = e_q;
        a_d         = a_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef BIST_ERRCNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_M0_WR;
                    e_d         = 2'd0;
                    a_d         = A_FIRST;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = {AW{1'b0}};
                    fail_data_d = {DW{1'b0}};
`ifdef BIST_ERRCNT_EN
                    err_cnt_d   = 8'd0;
`endif
                end
            end
            S_M0_WR: begin
                if (a_q == A_LAST) begin
                    state_d = S_RD;
                    e_d     = 2'd1;
                    a_d     = A_FIRST;
                end else begin
                    a_d     = a_q + 1'b1;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
`ifdef BIST_ERRCNT_EN
                // Record the first mismatch, count all of them, never abort.
                if (mismatch) begin
                    if (err_cnt_q == 8'd0) begin
                        fail_addr_d = a_q;
                        fail_data_d = ram_o;
                    end
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                if (e_q == 2'd3) begin
                    if (a_q == A_FIRST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == 8'd0);
                    end else begin
                        state_d = S_RD;
                        a_d     = a_q - 1'b1;
                    end
                end else begin
                    state_d = S_WR;
                end
`else
                if (mismatch) begin
                    // First mismatch ends the run; no further RAM access.
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = a_q;
                    fail_data_d = ram_o;
                end else if (e_q == 2'd3) begin
                    if (a_q == A_FIRST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        a_d     = a_q - 1'b1;
                    end
                end else begin
                    state_d = S_WR;
                end
`endif
            end
            S_WR: begin
                state_d = S_RD;
                if (e_q == 2'd1) begin
                    if (a_q == A_LAST) begin
                        e_d = 2'd2;
                        a_d = A_LAST;
                    end else begin
                        a_d = a_q + 1'b1;
                    end
                end else begin
                    if (a_q == A_FIRST) begin
                        e_d = 2'd3;
                        a_d = A_LAST;
                    end else begin
                        a_d = a_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // RAM drive derived from the upcoming state so the port is registered
    // and aligned with the state it belongs to.
    always_comb begin
        ram_cs_d   = (state_d == S_M0_WR) || (state_d == S_RD) || (state_d == S_WR);
        ram_rw_d   = !((state_d == S_M0_WR) || (state_d == S_WR));
        ram_addr_d = a_d;
        ram_d_d    = {DW{1'b0}};
        if (state_d == S_M0_WR) begin
            ram_d_d = PAT;
        end else if (state_d == S_WR) begin
            ram_d_d = (e_d == 2'd1) ? ~PAT : PAT;
        end
    end

    // State and output registers; reset drops RAM select immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            e_q         <= 2'd0;
            a_q         <= {AW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= {AW{1'b0}};
            fail_data_q <= {DW{1'b0}};
            ram_d_q     <= {DW{1'b0}};
            ram_addr_q  <= {AW{1'b0}};
            ram_cs_q    <= 1'b0;
            ram_rw_q    <= 1'b1;
`ifdef BIST_ERRCNT_EN
            err_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            e_q         <= e_d;
            a_q         <= a_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            ram_d_q     <= ram_d_d;
            ram_addr_q  <= ram_addr_d;
            ram_cs_q    <= ram_cs_d;
            ram_rw_q    <= ram_rw_d;
`ifdef BIST_ERRCNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign ram_d     = ram_d_q;
    assign ram_addr  = ram_addr_q;
    assign ram_cs    = ram_cs_q;
    assign ram_rw    = ram_rw_q;
`ifdef BIST_ERRCNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire
